// File: rtl/axi_read_arbiter.sv
// rtl/axi_read_arbiter.sv - two-master AXI read-address arbiter, one read outstanding
//
// Purpose: shares the AR path between M0 (IF) and M1 (MEM). A grant is taken at the
// master AR handshake and held until the last R beat of that read is accepted.
// Optional build macro ARB_RR_EN: round-robin on contention (pointer moves on release).
// Without it: fixed priority, M1 over M0.
//
// Ports:
//   ACLK, ARESETn                  clock, async active-low reset
//   ARVALID/ARADDR/ARID/ARLEN/ARSIZE/ARBURST_M0/M1   master AR requests
//   ARREADY_M0/M1                  AR accept to masters (combinational, IDLE only)
//   ARVALID/ARADDR/ARID/ARLEN/ARSIZE/ARBURST_S       registered AR to the decoder
//   ARREADY_S                      decoder accept
//   RVALID_S, RREADY_S, RLAST_S    R handshake of the granted path
//   GRANT_M0/M1                    one-hot owner, 0/0 when idle
module axi_read_arbiter #(
  parameter int ADDR_W = 32,
  parameter int ID_W   = 4,
  parameter int IDS_W  = 8
) (
  input  logic              ACLK,
  input  logic              ARESETn,
  input  logic              ARVALID_M0,
  input  logic [ADDR_W-1:0] ARADDR_M0,
  input  logic [ID_W-1:0]   ARID_M0,
  input  logic [3:0]        ARLEN_M0,
  input  logic [2:0]        ARSIZE_M0,
  input  logic [1:0]        ARBURST_M0,
  output logic              ARREADY_M0,
  input  logic              ARVALID_M1,
  input  logic [ADDR_W-1:0] ARADDR_M1,
  input  logic [ID_W-1:0]   ARID_M1,
  input  logic [3:0]        ARLEN_M1,
  input  logic [2:0]        ARSIZE_M1,
  input  logic [1:0]        ARBURST_M1,
  output logic              ARREADY_M1,
  output logic              ARVALID_S,
  output logic [ADDR_W-1:0] ARADDR_S,
  output logic [IDS_W-1:0]  ARID_S,
  output logic [3:0]        ARLEN_S,
  output logic [2:0]        ARSIZE_S,
  output logic [1:0]        ARBURST_S,
  input  logic              ARREADY_S,
  input  logic              RVALID_S,
  input  logic              RREADY_S,
  input  logic              RLAST_S,
  output logic              GRANT_M0,
  output logic              GRANT_M1
);

  localparam int TAG_W = IDS_W - ID_W;
  localparam logic [TAG_W-1:0] TAG_M0 = TAG_W'(1);
  localparam logic [TAG_W-1:0] TAG_M1 = TAG_W'(2);

  typedef enum logic [1:0] {IDLE = 2'd0, ADDR = 2'd1, DATA = 2'd2} state_t;

  state_t state;
  logic   pick_m1;
  logic   req_any;
  logic   r_last_hs;

`ifdef ARB_RR_EN
  // 0: M0 wins the next contention, 1: M1 wins it
  logic rr_ptr;
  assign pick_m1 = ARVALID_M1 & (~ARVALID_M0 | rr_ptr);
`else
  assign pick_m1 = ARVALID_M1;
`endif

  assign req_any   = ARVALID_M0 | ARVALID_M1;
  assign r_last_hs = RVALID_S & RREADY_S & RLAST_S;

  // Gated by reset so every output reads 0 while ARESETn is low
  assign ARREADY_M0 = ARESETn & (state == IDLE) & ARVALID_M0 & ~pick_m1;
  assign ARREADY_M1 = ARESETn & (state == IDLE) & pick_m1;

  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      state     <= IDLE;
      ARVALID_S <= 1'b0;
      ARADDR_S  <= '0;
      ARID_S    <= '0;
      ARLEN_S   <= '0;
      ARSIZE_S  <= '0;
      ARBURST_S <= '0;
      GRANT_M0  <= 1'b0;
      GRANT_M1  <= 1'b0;
`ifdef ARB_RR_EN
      rr_ptr    <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (req_any) begin
            ARVALID_S <= 1'b1;
            ARADDR_S  <= pick_m1 ? ARADDR_M1  : ARADDR_M0;
            ARID_S    <= pick_m1 ? {TAG_M1, ARID_M1} : {TAG_M0, ARID_M0};
            ARLEN_S   <= pick_m1 ? ARLEN_M1   : ARLEN_M0;
            ARSIZE_S  <= pick_m1 ? ARSIZE_M1  : ARSIZE_M0;
            ARBURST_S <= pick_m1 ? ARBURST_M1 : ARBURST_M0;
            GRANT_M0  <= ~pick_m1;
            GRANT_M1  <= pick_m1;
            state     <= ADDR;
          end
        end
        ADDR: begin
          if (ARREADY_S) begin
            ARVALID_S <= 1'b0;
            state     <= DATA;
          end
        end
        DATA: begin
          // Release: a request seen in this cycle is not taken; it is acked next cycle in IDLE
          if (r_last_hs) begin
            ARADDR_S  <= '0;
            ARID_S    <= '0;
            ARLEN_S   <= '0;
            ARSIZE_S  <= '0;
            ARBURST_S <= '0;
            GRANT_M0  <= 1'b0;
            GRANT_M1  <= 1'b0;
            state     <= IDLE;
`ifdef ARB_RR_EN
            rr_ptr    <= GRANT_M0;  // favour the master that did not just own the bus
`endif
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_axi_read_arbiter.sv
// tb/tb_axi_read_arbiter.sv - self-checking bench for axi_read_arbiter
module tb_axi_read_arbiter;

  logic        ACLK = 1'b0;
  logic        ARESETn = 1'b0;
  logic        ARVALID_M0 = 1'b0, ARVALID_M1 = 1'b0;
  logic [31:0] ARADDR_M0 = '0, ARADDR_M1 = '0;
  logic [3:0]  ARID_M0 = '0, ARID_M1 = '0, ARLEN_M0 = '0, ARLEN_M1 = '0;
  logic [2:0]  ARSIZE_M0 = '0, ARSIZE_M1 = '0;
  logic [1:0]  ARBURST_M0 = '0, ARBURST_M1 = '0;
  logic        ARREADY_M0, ARREADY_M1;
  logic        ARVALID_S;
  logic [31:0] ARADDR_S;
  logic [7:0]  ARID_S;
  logic [3:0]  ARLEN_S;
  logic [2:0]  ARSIZE_S;
  logic [1:0]  ARBURST_S;
  logic        ARREADY_S = 1'b0, RVALID_S = 1'b0, RREADY_S = 1'b0, RLAST_S = 1'b0;
  logic        GRANT_M0, GRANT_M1;

  int n_cmp = 0;
  int n_err = 0;
  int rr_next = 0;  // reference model: master favoured on the next contention

  axi_read_arbiter #(.ADDR_W(32), .ID_W(4), .IDS_W(8)) dut (
    .ACLK(ACLK), .ARESETn(ARESETn),
    .ARVALID_M0(ARVALID_M0), .ARADDR_M0(ARADDR_M0), .ARID_M0(ARID_M0), .ARLEN_M0(ARLEN_M0),
    .ARSIZE_M0(ARSIZE_M0), .ARBURST_M0(ARBURST_M0), .ARREADY_M0(ARREADY_M0),
    .ARVALID_M1(ARVALID_M1), .ARADDR_M1(ARADDR_M1), .ARID_M1(ARID_M1), .ARLEN_M1(ARLEN_M1),
    .ARSIZE_M1(ARSIZE_M1), .ARBURST_M1(ARBURST_M1), .ARREADY_M1(ARREADY_M1),
    .ARVALID_S(ARVALID_S), .ARADDR_S(ARADDR_S), .ARID_S(ARID_S), .ARLEN_S(ARLEN_S),
    .ARSIZE_S(ARSIZE_S), .ARBURST_S(ARBURST_S), .ARREADY_S(ARREADY_S),
    .RVALID_S(RVALID_S), .RREADY_S(RREADY_S), .RLAST_S(RLAST_S),
    .GRANT_M0(GRANT_M0), .GRANT_M1(GRANT_M1)
  );

  always #5 ACLK = ~ACLK;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, got running want finished");
    $fatal(1, "watchdog");
  end

  // ---------------- reference model ----------------
  function automatic int model_winner(bit v0, bit v1);
    if (!v0 && !v1) return -1;
    if (v0 && !v1) return 0;
    if (v1 && !v0) return 1;
`ifdef ARB_RR_EN
    return rr_next;
`else
    return 1;
`endif
  endfunction

  function automatic logic [7:0] model_id(int m, logic [3:0] id);
    return {(m == 1) ? 4'h2 : 4'h1, id};
  endfunction

  function automatic void model_release(int w);
    rr_next = 1 - w;
  endfunction

  // ---------------- stimulus drivers (no checking) ----------------
  task automatic idle_inputs();
    ARVALID_M0 = 0; ARVALID_M1 = 0; ARREADY_S = 0;
    RVALID_S = 0; RREADY_S = 0; RLAST_S = 0;
  endtask

  task automatic set_req(int m, logic [31:0] a, logic [3:0] id, logic [3:0] len,
                         logic [2:0] sz, logic [1:0] bu);
    if (m == 0) begin
      ARVALID_M0 = 1; ARADDR_M0 = a; ARID_M0 = id; ARLEN_M0 = len; ARSIZE_M0 = sz; ARBURST_M0 = bu;
    end else begin
      ARVALID_M1 = 1; ARADDR_M1 = a; ARID_M1 = id; ARLEN_M1 = len; ARSIZE_M1 = sz; ARBURST_M1 = bu;
    end
  endtask

  task automatic addr_accept();
    ARREADY_S = 1; @(negedge ACLK); ARREADY_S = 0;
  endtask

  task automatic beats(int n);
    for (int i = 0; i < n; i++) begin
      RVALID_S = 1; RREADY_S = 1; RLAST_S = (i == n - 1);
      @(negedge ACLK);
    end
    RVALID_S = 0; RREADY_S = 0; RLAST_S = 0;
  endtask

  task automatic apply_reset();
    idle_inputs(); ARESETn = 0; @(negedge ACLK); ARESETn = 1; rr_next = 0; @(negedge ACLK);
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    idle_inputs(); ARESETn = 0; @(negedge ACLK); @(negedge ACLK);
    n_cmp++; if ({ARVALID_S, ARADDR_S, ARID_S, ARLEN_S, ARSIZE_S, ARBURST_S, GRANT_M0, GRANT_M1, ARREADY_M0, ARREADY_M1} !== '0)
      begin n_err++; $display("FAIL reset_outputs got %0h want 0", {ARVALID_S, ARADDR_S, ARID_S, GRANT_M0, GRANT_M1}); end
    ARESETn = 1; rr_next = 0; @(negedge ACLK);
    set_req(0, 32'hABCD_0000, 4'h5, 4'h1, 3'd2, 2'd1);
    @(negedge ACLK); ARVALID_M0 = 0;
    addr_accept();
    n_cmp++; if (GRANT_M0 !== 1'b1) begin n_err++; $display("FAIL reset_pre_grant got %b want 1", GRANT_M0); end
    RVALID_S = 1; RREADY_S = 1;
    #2 ARESETn = 0;
    #1;
    n_cmp++; if ({ARVALID_S, ARADDR_S, ARID_S, ARLEN_S, GRANT_M0, GRANT_M1, ARREADY_M0, ARREADY_M1} !== '0)
      begin n_err++; $display("FAIL reset_async got %0h want 0", {ARVALID_S, ARADDR_S, ARID_S, GRANT_M0, GRANT_M1}); end
    idle_inputs(); @(negedge ACLK); ARESETn = 1; rr_next = 0; @(negedge ACLK);
    ARVALID_M1 = 1; #1;
    n_cmp++; if ({ARREADY_M0, ARREADY_M1} !== 2'b01) begin n_err++; $display("FAIL reset_idle_after got %b want 01", {ARREADY_M0, ARREADY_M1}); end
    @(negedge ACLK); ARVALID_M1 = 0;
    addr_accept(); beats(1); model_release(1);
  endtask

  task automatic test_single_m0();
    set_req(0, 32'h0000_0100, 4'h3, 4'd0, 3'd2, 2'd1); #1;
    n_cmp++; if ({ARREADY_M0, ARREADY_M1} !== 2'b10) begin n_err++; $display("FAIL single_ready got %b want 10", {ARREADY_M0, ARREADY_M1}); end
    @(negedge ACLK); ARVALID_M0 = 0;
    n_cmp++; if (ARVALID_S !== 1'b1) begin n_err++; $display("FAIL single_arvalid got %b want 1", ARVALID_S); end
    n_cmp++; if (ARADDR_S !== 32'h100) begin n_err++; $display("FAIL single_addr got %h want 00000100", ARADDR_S); end
    n_cmp++; if (ARID_S !== 8'h13) begin n_err++; $display("FAIL single_id got %h want 13", ARID_S); end
    n_cmp++; if ({GRANT_M0, GRANT_M1} !== 2'b10) begin n_err++; $display("FAIL single_grant got %b want 10", {GRANT_M0, GRANT_M1}); end
    addr_accept();
    n_cmp++; if ({ARVALID_S, GRANT_M0} !== 2'b01) begin n_err++; $display("FAIL single_data got %b want 01", {ARVALID_S, GRANT_M0}); end
    beats(1);
    n_cmp++; if ({GRANT_M0, GRANT_M1} !== 2'b00) begin n_err++; $display("FAIL single_release got %b want 00", {GRANT_M0, GRANT_M1}); end
    model_release(0);
  endtask

  task automatic test_contention();
    int w;
    apply_reset();
    for (int k = 0; k < 2; k++) begin
      set_req(0, 32'h0000_2000, 4'h1, 4'd0, 3'd2, 2'd1);
      set_req(1, 32'h0000_4000, 4'h2, 4'd0, 3'd2, 2'd1);
      w = model_winner(1, 1); #1;
      n_cmp++; if ({ARREADY_M0, ARREADY_M1} !== {w == 0, w == 1}) begin n_err++; $display("FAIL contend_ready%0d got %b want %b", k, {ARREADY_M0, ARREADY_M1}, {w == 0, w == 1}); end
      @(negedge ACLK);
      if (w == 0) ARVALID_M0 = 0; else ARVALID_M1 = 0;
      n_cmp++; if (ARID_S !== model_id(w, (w == 0) ? 4'h1 : 4'h2)) begin n_err++; $display("FAIL contend_id%0d got %h want %h", k, ARID_S, model_id(w, (w == 0) ? 4'h1 : 4'h2)); end
      addr_accept(); #1;
      n_cmp++; if ({ARREADY_M0, ARREADY_M1} !== 2'b00) begin n_err++; $display("FAIL contend_loser%0d got %b want 00", k, {ARREADY_M0, ARREADY_M1}); end
      beats(1); model_release(w);
    end
    idle_inputs(); @(negedge ACLK);
  endtask

  task automatic test_addr_stall();
    set_req(0, 32'h0000_5A5C, 4'h7, 4'd2, 3'd1, 2'd2);
    @(negedge ACLK);
    set_req(0, 32'h0000_0040, 4'h1, 4'd0, 3'd0, 2'd0);
    set_req(1, 32'h0000_0080, 4'h2, 4'd0, 3'd0, 2'd0);
    for (int i = 0; i < 5; i++) begin
      n_cmp++; if ({ARVALID_S, ARADDR_S, ARID_S, ARLEN_S, ARSIZE_S, ARBURST_S} !== {1'b1, 32'h0000_5A5C, 8'h17, 4'd2, 3'd1, 2'd2})
        begin n_err++; $display("FAIL stall_hold%0d got %b/%h/%h want 1/00005a5c/17", i, ARVALID_S, ARADDR_S, ARID_S); end
      #1;
      n_cmp++; if ({ARREADY_M0, ARREADY_M1} !== 2'b00) begin n_err++; $display("FAIL stall_noready%0d got %b want 00", i, {ARREADY_M0, ARREADY_M1}); end
      @(negedge ACLK);
    end
    idle_inputs(); addr_accept(); beats(3); model_release(0);
  endtask

  task automatic test_burst();
    set_req(1, 32'h1000_0000, 4'h4, 4'd3, 3'd2, 2'd1);
    @(negedge ACLK); ARVALID_M1 = 0;
    set_req(0, 32'h0000_0300, 4'h9, 4'd0, 3'd2, 2'd1);
    n_cmp++; if ({GRANT_M0, GRANT_M1, ARADDR_S} !== {2'b01, 32'h1000_0000}) begin n_err++; $display("FAIL burst_grant got %b/%h want 01/10000000", {GRANT_M0, GRANT_M1}, ARADDR_S); end
    addr_accept();
    for (int i = 0; i < 4; i++) begin
      RVALID_S = 1; RREADY_S = 1; RLAST_S = (i == 3); #1;
      n_cmp++; if (ARREADY_M0 !== 1'b0) begin n_err++; $display("FAIL burst_beat%0d_ready got %b want 0", i, ARREADY_M0); end
      @(negedge ACLK);
      if (i < 3) begin
        n_cmp++; if (GRANT_M1 !== 1'b1) begin n_err++; $display("FAIL burst_beat%0d_grant got %b want 1", i, GRANT_M1); end
      end
    end
    RVALID_S = 0; RREADY_S = 0; RLAST_S = 0; model_release(1);
    n_cmp++; if ({GRANT_M0, GRANT_M1} !== 2'b00) begin n_err++; $display("FAIL burst_release got %b want 00", {GRANT_M0, GRANT_M1}); end
    #1;
    n_cmp++; if (ARREADY_M0 !== 1'b1) begin n_err++; $display("FAIL burst_after_bubble got %b want 1", ARREADY_M0); end
    @(negedge ACLK); ARVALID_M0 = 0;
    n_cmp++; if ({GRANT_M0, ARID_S} !== {1'b1, 8'h19}) begin n_err++; $display("FAIL burst_next_m0 got %b/%h want 1/19", GRANT_M0, ARID_S); end
    addr_accept(); beats(1); model_release(0);
  endtask

  task automatic test_default_slave();
    set_req(0, 32'h3000_0000, 4'hE, 4'd1, 3'd2, 2'd1);
    @(negedge ACLK); ARVALID_M0 = 0;
    n_cmp++; if ({ARVALID_S, ARADDR_S, ARID_S} !== {1'b1, 32'h3000_0000, 8'h1E}) begin n_err++; $display("FAIL dflt_addr got %b/%h/%h want 1/30000000/1e", ARVALID_S, ARADDR_S, ARID_S); end
    addr_accept();
    RVALID_S = 1; RREADY_S = 1; RLAST_S = 0; @(negedge ACLK);
    n_cmp++; if (GRANT_M0 !== 1'b1) begin n_err++; $display("FAIL dflt_hold got %b want 1", GRANT_M0); end
    beats(1);
    n_cmp++; if ({GRANT_M0, GRANT_M1} !== 2'b00) begin n_err++; $display("FAIL dflt_release got %b want 00", {GRANT_M0, GRANT_M1}); end
    model_release(0);
  endtask

  task automatic test_random();
    int w, v, remaining, guard, stall;
    logic [31:0] a [2];
    logic [3:0] id [2], len [2];
    logic [2:0] sz [2];
    logic [1:0] bu [2];
    for (int t = 0; t < 40; t++) begin
      v = $urandom_range(1, 3);
      for (int m = 0; m < 2; m++) begin
        a[m] = $urandom; id[m] = 4'($urandom); len[m] = 4'($urandom_range(0, 3));
        sz[m] = 3'($urandom); bu[m] = 2'($urandom);
        if (v[m]) set_req(m, a[m], id[m], len[m], sz[m], bu[m]);
      end
      w = model_winner(v[0], v[1]); #1;
      n_cmp++; if ({ARREADY_M0, ARREADY_M1} !== {w == 0, w == 1}) begin n_err++; $display("FAIL rnd%0d_ready got %b want %b", t, {ARREADY_M0, ARREADY_M1}, {w == 0, w == 1}); end
      @(negedge ACLK); ARVALID_M0 = 0; ARVALID_M1 = 0;
      n_cmp++; if ({ARVALID_S, ARADDR_S, ARID_S, ARLEN_S, ARSIZE_S, ARBURST_S, GRANT_M0, GRANT_M1} !==
                   {1'b1, a[w], model_id(w, id[w]), len[w], sz[w], bu[w], w == 0, w == 1})
        begin n_err++; $display("FAIL rnd%0d_payload got %h/%h/%b want %h/%h/%0d", t, ARADDR_S, ARID_S, {GRANT_M0, GRANT_M1}, a[w], model_id(w, id[w]), w); end
      stall = $urandom_range(0, 3);
      for (int s = 0; s < stall; s++) begin
        @(negedge ACLK);
        n_cmp++; if (ARVALID_S !== 1'b1) begin n_err++; $display("FAIL rnd%0d_stall got %b want 1", t, ARVALID_S); end
      end
      addr_accept();
      n_cmp++; if (ARVALID_S !== 1'b0) begin n_err++; $display("FAIL rnd%0d_arvalid_drop got %b want 0", t, ARVALID_S); end
      remaining = int'(len[w]) + 1; guard = 0;
      while (remaining > 0 && guard < 200) begin
        RVALID_S = 1'($urandom); RREADY_S = 1'($urandom); RLAST_S = (remaining == 1);
        ARVALID_M0 = 1'($urandom); ARVALID_M1 = 1'($urandom); #1;
        n_cmp++; if ({ARREADY_M0, ARREADY_M1} !== 2'b00) begin n_err++; $display("FAIL rnd%0d_data_ready got %b want 00", t, {ARREADY_M0, ARREADY_M1}); end
        @(negedge ACLK); guard++;
        if (RVALID_S && RREADY_S) remaining--;
      end
      idle_inputs();
      n_cmp++; if ({GRANT_M0, GRANT_M1, ARVALID_S} !== 3'b000 || remaining != 0) begin n_err++; $display("FAIL rnd%0d_release got %b want 000", t, {GRANT_M0, GRANT_M1, ARVALID_S}); end
      model_release(w);
    end
  endtask

  initial begin
    test_reset();
    test_single_m0();
    test_contention();
    test_addr_stall();
    test_burst();
    test_default_slave();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
